// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank.
//   mode_e     : per-channel operating mode (2 bits)
//   DIR_UP/DN  : breathe direction encodings
//   ch_width() : channel index width for a given channel count (min 1)
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Configuration write port of the LED PWM bank.
//   cfg_we   : write strobe, one cycle per write
//   cfg_ch   : target channel (values >= N_CH are dropped by the bank)
//   cfg_mode : 0=OFF 1=STATIC 2=BREATHE 3=BLINK
//   cfg_duty : STATIC duty / BLINK on-level
// Handshake: valid-only. cfg_we is the valid; there is no ready because the
// bank accepts every write in the cycle it is presented. Fields are only
// meaningful while cfg_we is high.
// Modports: master (register block side), slave (bank side).
interface led_pwm_if
    import led_pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PWM_W = 8
) ();

    localparam int CH_W = ch_width(N_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty);

endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel: shadow config, active level, mode logic and output flops.
//   clk, arstn : clock, asynchronous active-low reset
//   wr_en      : write this channel's shadow mode/duty this cycle
//   wr_mode    : new shadow mode
//   wr_duty    : new shadow duty
//   boundary   : high in the cycle where the shared pwm_cnt is all-ones
//   step       : a brightness step is due at this boundary
//   pwm_cnt    : shared PWM counter
//   led, led_n : registered PWM output and its separately registered complement
// Optional build macro: LED_PWM_GAMMA_EN squares the level (>>PWM_W) before
// the comparison; the squared value is latched at the boundary alongside the
// level, so output latency is the same either way.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             wr_en,
    input  mode_e            wr_mode,
    input  logic [PWM_W-1:0] wr_duty,
    input  logic             boundary,
    input  logic             step,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic             led_n
);

    localparam logic [PWM_W-1:0] LVL_MAX = '1;

    mode_e            sh_mode, act_mode;
    logic [PWM_W-1:0] sh_duty;
    logic [PWM_W-1:0] level, level_d;
    logic [PWM_W-1:0] cmp_q, cmp_d;
    logic             dir, dir_d;
    logic             blink_on, blink_on_d;
    logic             hit;

    // Next active state, consumed only on the boundary edge. The shadow
    // registers read here are the values held before that edge, so a write
    // landing in the boundary cycle waits for the following boundary.
    always_comb begin
        level_d    = level;
        dir_d      = dir;
        blink_on_d = blink_on;
        case (sh_mode)
            MODE_OFF:    level_d = '0;
            MODE_STATIC: level_d = sh_duty;
            MODE_BREATHE: begin
                if (act_mode != MODE_BREATHE) begin
                    level_d = '0;
                    dir_d   = DIR_UP;
                end else if (step) begin
                    if (dir == DIR_UP) begin
                        if (level == LVL_MAX) begin
                            dir_d   = DIR_DOWN;
                            level_d = LVL_MAX - 1'b1;
                        end else begin
                            level_d = level + 1'b1;
                        end
                    end else begin
                        if (level == '0) begin
                            dir_d   = DIR_UP;
                            level_d = PWM_W'(1);
                        end else begin
                            level_d = level - 1'b1;
                        end
                    end
                end
            end
            MODE_BLINK: begin
                // Phase bit rather than testing the level so a duty of 0
                // still alternates phases and a duty rewrite applies to the
                // next on-phase.
                if (act_mode != MODE_BLINK) begin
                    blink_on_d = 1'b1;
                end else if (step) begin
                    blink_on_d = ~blink_on;
                end
                level_d = blink_on_d ? sh_duty : '0;
            end
            default: level_d = '0;
        endcase
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_W-1:0] lvl_wide;
    logic [2*PWM_W-1:0] lvl_sq;
    assign lvl_wide = {{PWM_W{1'b0}}, level_d};
    assign lvl_sq   = lvl_wide * lvl_wide;
    assign cmp_d    = lvl_sq[2*PWM_W-1:PWM_W];
`else
    assign cmp_d    = level_d;
`endif

    assign hit = (cmp_q > pwm_cnt);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sh_mode  <= MODE_OFF;
            sh_duty  <= '0;
            act_mode <= MODE_OFF;
            level    <= '0;
            dir      <= DIR_UP;
            blink_on <= 1'b0;
            cmp_q    <= '0;
            led      <= 1'b0;
            led_n    <= 1'b0;
        end else begin
            if (wr_en) begin
                sh_mode <= wr_mode;
                sh_duty <= wr_duty;
            end
            if (boundary) begin
                act_mode <= sh_mode;
                level    <= level_d;
                dir      <= dir_d;
                blink_on <= blink_on_d;
                cmp_q    <= cmp_d;
            end
            led   <= hit;
            led_n <= ~hit;
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM engine.
//   clk, arstn : clock, asynchronous active-low reset
//   cfg        : configuration write port (led_pwm_if.slave)
//   led_o      : per-channel PWM output, registered
//   led_n_o    : complement of led_o from its own register (0 in reset)
//   tick_o     : one-cycle pulse per brightness step
//   period_o   : one-cycle pulse after each PWM wrap
// Parameters: N_CH channels, PWM_W counter/duty bits, STEP_DIV clk cycles per
// step. Optional build macro LED_PWM_GAMMA_EN (see led_pwm_chan).
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 25000
) (
    input  logic            clk,
    input  logic            arstn,
    led_pwm_if.slave        cfg,
    output logic [N_CH-1:0] led_o,
    output logic [N_CH-1:0] led_n_o,
    output logic            tick_o,
    output logic            period_o
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int PRE_W = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             step_pend;
    logic             boundary;
    logic             step;

    assign boundary = (pwm_cnt == '1);
    // A tick arriving in the boundary cycle itself still counts for this
    // boundary; any number of ticks in one period collapse into one step.
    assign step     = step_pend | tick_o;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pre_cnt   <= '0;
            tick_o    <= 1'b0;
            pwm_cnt   <= '0;
            period_o  <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            tick_o    <= (pre_cnt == PRE_LAST);
            pwm_cnt   <= pwm_cnt + 1'b1;
            period_o  <= boundary;
            step_pend <= boundary ? 1'b0 : step;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_en;
        // Exact index match, so channel numbers >= N_CH select nothing.
        assign wr_en = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        led_pwm_chan #(.PWM_W(PWM_W)) u_chan (
            .clk      (clk),
            .arstn    (arstn),
            .wr_en    (wr_en),
            .wr_mode  (mode_e'(cfg.cfg_mode)),
            .wr_duty  (cfg.cfg_duty),
            .boundary (boundary),
            .step     (step),
            .pwm_cnt  (pwm_cnt),
            .led      (led_o[i]),
            .led_n    (led_n_o[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Testbench for led_pwm_bank. Five channels so that cfg_ch values 5..7 are
// representable and out of range; short PWM period for run length.
module tb_led_pwm_bank;

    localparam int N_CH     = 5;
    localparam int PWM_W    = 6;
    localparam int STEP_DIV = 40;
    localparam int P        = 1 << PWM_W;
    localparam int LMAX     = P - 1;
    localparam int EW       = N_CH * PWM_W;

    typedef struct {
        int at;
        int ch;
        int mode;
        int duty;
    } wr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arstn = 1'b1;
    always #5 clk = ~clk;

    logic [N_CH-1:0] led_o, led_n_o;
    logic            tick_o, period_o;

    led_pwm_if #(.N_CH(N_CH), .PWM_W(PWM_W)) cfg_if ();

    led_pwm_bank #(.N_CH(N_CH), .PWM_W(PWM_W), .STEP_DIV(STEP_DIV)) dut (
        .clk      (clk),
        .arstn    (arstn),
        .cfg      (cfg_if),
        .led_o    (led_o),
        .led_n_o  (led_n_o),
        .tick_o   (tick_o),
        .period_o (period_o)
    );

    // Clock edges seen since reset release.
    int cyc;
    always @(posedge clk or negedge arstn) begin
        if (!arstn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    wr_t           wr_q[$];

    // ---------------- driver tasks ----------------
    // Call right after a negedge; the write is sampled on the next posedge.
    task automatic write_cfg(input int ch, input int mode, input int duty);
        wr_t w;
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = 3'(ch);
        cfg_if.cfg_mode = 2'(mode);
        cfg_if.cfg_duty = PWM_W'(duty);
        w.at = cyc + 1; w.ch = ch; w.mode = mode; w.duty = duty;
        wr_q.push_back(w);
        @(negedge clk);
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0b expected %0b", name, cyc, act, req);
        end
    endtask

    task automatic do_reset(input int hold);
        arstn = 1'b0;
        wr_q.delete();
        #1;
        check_bit("rst_led_o",    |led_o,    1'b0);
        check_bit("rst_led_n_o",  |led_n_o,  1'b0);
        check_bit("rst_tick_o",   tick_o,    1'b0);
        check_bit("rst_period_o", period_o,  1'b0);
        wait_cycles(hold);
        arstn = 1'b1;
    endtask

    // ---------------- reference model ----------------
    int sh_m[N_CH], sh_d[N_CH], act_m[N_CH], n_step[N_CH];

    // A step is due at boundary p if any tick pulse appeared during the
    // period that ends there (ticks are at edges j with j % STEP_DIV == 0).
    function automatic bit step_due(input int p);
        int lo, hi;
        lo = (p == 1) ? 1 : P * (p - 1);
        hi = P * p - 1;
        return (hi / STEP_DIV) > ((lo - 1) / STEP_DIV);
    endfunction

    function automatic int triangle(input int n);
        int t;
        t = n % (2 * LMAX);
        return (t <= LMAX) ? t : 2 * LMAX - t;
    endfunction

    initial begin : model
        bit            fresh;
        int            k, lvl;
        bit            st;
        logic [EW-1:0] e;
        fresh = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!arstn) begin
                fresh = 1'b1;
                continue;
            end
            if (fresh) begin
                for (int i = 0; i < N_CH; i++) begin
                    sh_m[i] = 0; sh_d[i] = 0; act_m[i] = 0; n_step[i] = 0;
                end
                exp_q.delete();
                exp_q.push_back('0);
                fresh = 1'b0;
            end
            k = cyc;
            if (k % P == 0) begin
                st = step_due(k / P);
                e  = '0;
                for (int i = 0; i < N_CH; i++) begin
                    lvl = 0;
                    case (sh_m[i])
                        1: lvl = sh_d[i];
                        2: begin
                            if (act_m[i] != 2) n_step[i] = 0;
                            else if (st)       n_step[i]++;
                            lvl = triangle(n_step[i]);
                        end
                        3: begin
                            if (act_m[i] != 3) n_step[i] = 0;
                            else if (st)       n_step[i]++;
                            lvl = (n_step[i] % 2 == 0) ? sh_d[i] : 0;
                        end
                        default: lvl = 0;
                    endcase
                    act_m[i] = sh_m[i];
`ifdef LED_PWM_GAMMA_EN
                    lvl = (lvl * lvl) >> PWM_W;
`endif
                    e[i*PWM_W +: PWM_W] = PWM_W'(lvl);
                end
                exp_q.push_back(e);
            end
            while (wr_q.size() > 0 && wr_q[0].at <= k) begin
                wr_t w;
                w = wr_q.pop_front();
                if (w.ch < N_CH) begin
                    sh_m[w.ch] = w.mode;
                    sh_d[w.ch] = w.duty;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int            hi[N_CH];
        int            k;
        logic [EW-1:0] e;
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!arstn) begin
                for (int i = 0; i < N_CH; i++) hi[i] = 0;
                continue;
            end
            k = cyc;
            check_bit("tick_o",   tick_o,   (k % STEP_DIV) == 0);
            check_bit("period_o", period_o, (k % P) == 0);
            checks++;
            if (led_n_o !== ~led_o) begin
                errors++;
                $display("FAIL led_n_o at cyc %0d: got %b expected %b", k, led_n_o, ~led_o);
            end
            for (int i = 0; i < N_CH; i++) hi[i] += int'(led_o[i]);
            if (k % P == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at cyc %0d: got no expected entry, required one", k);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < N_CH; i++) begin
                        checks++;
                        if (hi[i] != int'(e[i*PWM_W +: PWM_W])) begin
                            errors++;
                            $display("FAIL high_time ch%0d period ending cyc %0d: got %0d expected %0d",
                                     i, k, hi[i], e[i*PWM_W +: PWM_W]);
                        end
                    end
                end
                for (int i = 0; i < N_CH; i++) hi[i] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_mode = '0;
        cfg_if.cfg_duty = '0;

        #1;
        do_reset(3);
        wait_cycles(4 * P);

        // Directed: every mode, duty extremes, a full breathe triangle.
        write_cfg(0, 1, 0);
        write_cfg(1, 1, 16);
        write_cfg(4, 1, LMAX);
        write_cfg(3, 3, 50);
        write_cfg(2, 2, 0);
        wait_cycles(140 * P);

        // Write landing in the boundary cycle, then out-of-range channels.
        do @(negedge clk); while (cyc % P != P - 1);
        write_cfg(1, 1, 40);
        write_cfg(5, 1, 33);
        write_cfg(6, 3, 20);
        write_cfg(7, 0, 0);
        wait_cycles(3 * P);

        // Randomized writes.
        for (int n = 0; n < 60; n++) begin
            wait_cycles($urandom_range(0, 200));
            write_cfg($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, LMAX));
        end
        wait_cycles(4 * P);

        // Asynchronous reset in the middle of a breathe ramp.
        write_cfg(2, 0, 0);
        wait_cycles(2 * P);
        write_cfg(2, 2, 0);
        wait_cycles(40 * P + 17);
        #2;
        do_reset(5);
        wait_cycles(4 * P);
        write_cfg(1, 1, 32);
        wait_cycles(4 * P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
